comp_refill_ctrl: RTL and testbench

Parametrised refill controller for the dictionary-compressed instruction fetch path. It sits between the raw/compressed icache pair and memory. It accepts one line miss, fetches `NUM_BLOCKS` words, and looks up each word's three RV32 fields in the external dictionaries (one registered cycle per beat). It then fills exactly one cache: the compressed cache with packed keys when every field of every word hits and compression is enabled, otherwise the raw cache. Over the previous generation it adds a runtime compression enable, an abortable refill (`flush`), an explicit beat/lookup pipeline, and saturating fill statistics.

---
 rtl/comp_pkg.sv | 30 +++
 rtl/comp_sat_counter.sv | 19 +
 rtl/comp_refill_ctrl.sv | 158 +++++++++++++++
 tb/tb_comp_refill_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared types and field-split helper for the compressed-fetch refill path.
package comp_pkg;

  localparam int F1_VAL_W = 7;
  localparam int F2_VAL_W = 10;
  localparam int F3_VAL_W = 15;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LOOK,
    FILL
  } state_t;

  typedef struct packed {
    logic [F3_VAL_W-1:0] f3;
    logic [F2_VAL_W-1:0] f2;
    logic [F1_VAL_W-1:0] f1;
  } field_vals_t;

  // Splits an RV32 word into the three dictionary lookup values.
  function automatic field_vals_t comp_split(input logic [31:0] word);
    field_vals_t v;
    v.f1 = word[6:0];
    v.f2 = {word[31:25], word[14:12]};
    v.f3 = {word[24:15], word[11:7]};
    return v;
  endfunction

endpackage

// File: rtl/comp_sat_counter.sv
// Saturating up-counter used for the refill statistics.
module comp_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/comp_refill_ctrl.sv
// Line refill controller: fetches a line word by word, looks each word up in the
// external dictionaries, then fills either the compressed or the raw cache.
module comp_refill_ctrl
  import comp_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4,
  parameter int F1_KEY_W   = 3,
  parameter int F2_KEY_W   = 5,
  parameter int F3_KEY_W   = 8,
  parameter int CNT_W      = 16,
  localparam int KEY_W     = F1_KEY_W + F2_KEY_W + F3_KEY_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        miss_valid,
  output logic                        miss_ready,
  input  logic [31:0]                 miss_addr,
  input  logic                        comp_enable,
  input  logic                        flush,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  output logic [F1_VAL_W-1:0]         f1_val,
  output logic [F2_VAL_W-1:0]         f2_val,
  output logic [F3_VAL_W-1:0]         f3_val,
  input  logic                        f1_hit,
  input  logic                        f2_hit,
  input  logic                        f3_hit,
  input  logic [F1_KEY_W-1:0]         f1_key,
  input  logic [F2_KEY_W-1:0]         f2_key,
  input  logic [F3_KEY_W-1:0]         f3_key,
  output logic [31:0]                 fill_addr,
  output logic                        raw_fill_valid,
  output logic [32*NUM_BLOCKS-1:0]    raw_fill_data,
  output logic                        comp_fill_valid,
  output logic [KEY_W*NUM_BLOCKS-1:0] comp_fill_data,
  output logic [CNT_W-1:0]            stat_comp_lines,
  output logic [CNT_W-1:0]            stat_raw_lines
);

  localparam int                BEAT_W    = $clog2(NUM_BLOCKS);
  localparam logic [31:0]       LINE_MASK = 32'(NUM_BLOCKS * BLOCK_SIZE - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BLOCKS - 1);

  state_t                      state_q, state_d;
  logic [31:0]                 base_q;
  logic [31:0]                 word_q;
  logic [BEAT_W-1:0]           beat_q;
  logic                        ce_q;
  logic                        compressible_q;
  logic [32*NUM_BLOCKS-1:0]    raw_q;
  logic [KEY_W*NUM_BLOCKS-1:0] comp_q;
  logic                        accept;
  logic                        capture;
  logic                        lookup;
  logic                        all_hit;
  field_vals_t                 vals;

  assign vals   = comp_split(word_q);
  assign f1_val = vals.f1;
  assign f2_val = vals.f2;
  assign f3_val = vals.f3;

  assign all_hit = f1_hit & f2_hit & f3_hit;
  // flush only aborts acceptance/REQ/LOOK; a FILL in progress always completes
  assign accept  = (state_q == IDLE) && miss_valid && !flush;
  assign capture = (state_q == REQ) && mem_req_ready && !flush;
  assign lookup  = (state_q == LOOK) && !flush;

  assign fill_addr      = base_q;
  assign raw_fill_data  = raw_q;
  assign comp_fill_data = comp_q;

  always_comb begin
    state_d         = state_q;
    miss_ready      = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    raw_fill_valid  = 1'b0;
    comp_fill_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (accept) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = base_q + 32'(beat_q) * 32'(BLOCK_SIZE);
        if (flush)              state_d = IDLE;
        else if (mem_req_ready) state_d = LOOK;
      end
      LOOK: begin
        if (flush)                     state_d = IDLE;
        else if (beat_q == LAST_BEAT)  state_d = FILL;
        else                           state_d = REQ;
      end
      FILL: begin
        if (ce_q && compressible_q) comp_fill_valid = 1'b1;
        else                        raw_fill_valid  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      base_q         <= '0;
      word_q         <= '0;
      beat_q         <= '0;
      ce_q           <= 1'b0;
      compressible_q <= 1'b0;
      raw_q          <= '0;
      comp_q         <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q         <= miss_addr & ~LINE_MASK;
        ce_q           <= comp_enable;
        beat_q         <= '0;
        compressible_q <= 1'b1;
      end
      if (capture) begin
        word_q <= mem_req_rdata;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
          if (beat_q == BEAT_W'(i)) raw_q[i*32 +: 32] <= mem_req_rdata;
        end
      end
      if (lookup) begin
        compressible_q <= compressible_q & all_hit;
        if (all_hit) begin
          for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            if (beat_q == BEAT_W'(i)) comp_q[i*KEY_W +: KEY_W] <= {f3_key, f2_key, f1_key};
          end
        end
        if (beat_q != LAST_BEAT) beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  comp_sat_counter #(.CNT_W(CNT_W)) u_comp_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (comp_fill_valid),
    .count (stat_comp_lines)
  );

  comp_sat_counter #(.CNT_W(CNT_W)) u_raw_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (raw_fill_valid),
    .count (stat_raw_lines)
  );

endmodule

// File: tb/tb_comp_refill_ctrl.sv
// Directed bench for comp_refill_ctrl with a small memory and dictionary stand-in.
module tb_comp_refill_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          miss_valid = 1'b0;
  logic          miss_ready;
  logic [31:0]   miss_addr = '0;
  logic          comp_enable = 1'b0;
  logic          flush = 1'b0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic [31:0]   mem_req_addr;
  logic [31:0]   mem_req_rdata;
  logic [6:0]    f1_val;
  logic [9:0]    f2_val;
  logic [14:0]   f3_val;
  logic          f1_hit, f2_hit, f3_hit;
  logic [2:0]    f1_key;
  logic [4:0]    f2_key;
  logic [7:0]    f3_key;
  logic [31:0]   fill_addr;
  logic          raw_fill_valid;
  logic [127:0]  raw_fill_data;
  logic          comp_fill_valid;
  logic [63:0]   comp_fill_data;
  logic [CW-1:0] stat_comp_lines;
  logic [CW-1:0] stat_raw_lines;
  logic          kill_f3 = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory word = {~addr[15:0], addr[15:0]}; dictionaries hit everything unless
  // kill_f3 makes the field-3 lookup of the word at ...4C miss.
  assign mem_req_rdata = {~mem_req_addr[15:0], mem_req_addr[15:0]};
  assign f1_hit = 1'b1;
  assign f2_hit = 1'b1;
  assign f3_hit = !(kill_f3 && (f1_val == 7'h4C));
  assign f1_key = f1_val[2:0];
  assign f2_key = f2_val[4:0];
  assign f3_key = f3_val[7:0];

  comp_refill_ctrl #(
    .NUM_BLOCKS (4),
    .BLOCK_SIZE (4),
    .F1_KEY_W   (3),
    .F2_KEY_W   (5),
    .F3_KEY_W   (8),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .miss_valid      (miss_valid),
    .miss_ready      (miss_ready),
    .miss_addr       (miss_addr),
    .comp_enable     (comp_enable),
    .flush           (flush),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_rdata   (mem_req_rdata),
    .f1_val          (f1_val),
    .f2_val          (f2_val),
    .f3_val          (f3_val),
    .f1_hit          (f1_hit),
    .f2_hit          (f2_hit),
    .f3_hit          (f3_hit),
    .f1_key          (f1_key),
    .f2_key          (f2_key),
    .f3_key          (f3_key),
    .fill_addr       (fill_addr),
    .raw_fill_valid  (raw_fill_valid),
    .raw_fill_data   (raw_fill_data),
    .comp_fill_valid (comp_fill_valid),
    .comp_fill_data  (comp_fill_data),
    .stat_comp_lines (stat_comp_lines),
    .stat_raw_lines  (stat_raw_lines)
  );

  // Expected packed keys for an all-hit line, sliced straight from the field layout.
  function automatic logic [63:0] exp_comp(input logic [31:0] base);
    logic [63:0] r;
    logic [31:0] a, w;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = base + 32'(4 * i);
      w = {~a[15:0], a[15:0]};
      r[i*16 +: 16] = {w[17:15], w[11:7], w[26:25], w[14:12], w[2:0]};
    end
    return r;
  endfunction

  // Runs one miss from acceptance (edge 0) through 20 cycles and records what it saw.
  task automatic run_line(input logic [31:0] addr, input logic ce, input int stall,
                          input int ce_drop, input int flush_c, input int rst_c,
                          input logic kill,
                          output int fill_cyc, output int n_fill, output logic fill_comp,
                          output logic [31:0] fill_at, output logic [31:0] ra [4],
                          output int n_req, output int n_unstable, output int ready_cyc,
                          output int n_both);
    logic        prev_valid, prev_acc;
    logic [31:0] prev_addr;
    fill_cyc = 0; n_fill = 0; fill_comp = 1'b0; fill_at = '0;
    n_req = 0; n_unstable = 0; ready_cyc = 0; n_both = 0;
    for (int i = 0; i < 4; i++) ra[i] = '0;
    prev_valid = 1'b0; prev_acc = 1'b0; prev_addr = '0;
    kill_f3 = kill;
    @(negedge clk);
    miss_addr = addr; comp_enable = ce; miss_valid = 1'b1; mem_req_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      miss_valid    = 1'b0;
      mem_req_ready = !(c <= stall);
      comp_enable   = (ce_drop != 0 && c >= ce_drop) ? 1'b0 : ce;
      flush         = (c == flush_c);
      reset         = (c == rst_c);
      #1;
      if (mem_req_valid) begin
        if (prev_valid && !prev_acc && mem_req_addr !== prev_addr) n_unstable++;
        if (mem_req_ready) begin
          if (n_req < 4) ra[n_req] = mem_req_addr;
          n_req++;
        end
      end
      prev_valid = mem_req_valid;
      prev_addr  = mem_req_addr;
      prev_acc   = mem_req_valid && mem_req_ready;
      if (comp_fill_valid && raw_fill_valid) n_both++;
      if (comp_fill_valid || raw_fill_valid) begin
        n_fill++;
        if (fill_cyc == 0) begin
          fill_cyc = c; fill_comp = comp_fill_valid; fill_at = fill_addr;
        end
      end
      if (ready_cyc == 0 && miss_ready) ready_cyc = c;
    end
    flush = 1'b0; reset = 1'b0; mem_req_ready = 1'b1; kill_f3 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL rst_miss_ready got=%b exp=1", miss_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr got=%h exp=0", mem_req_addr); end
    checks++; if ({raw_fill_valid, comp_fill_valid} !== 2'b00) begin failures++; $display("FAIL rst_fill_valids got=%b exp=00", {raw_fill_valid, comp_fill_valid}); end
    checks++; if (raw_fill_data !== 128'h0 || comp_fill_data !== 64'h0) begin failures++; $display("FAIL rst_fill_data raw=%h comp=%h exp=0", raw_fill_data, comp_fill_data); end
    checks++; if (fill_addr !== 32'h0) begin failures++; $display("FAIL rst_fill_addr got=%h exp=0", fill_addr); end
    checks++; if (stat_comp_lines !== '0 || stat_raw_lines !== '0) begin failures++; $display("FAIL rst_counters comp=%0d raw=%0d exp=0", stat_comp_lines, stat_raw_lines); end
    checks++; if ({f1_val, f2_val, f3_val} !== 32'h0) begin failures++; $display("FAIL rst_vals got=%h exp=0", {f1_val, f2_val, f3_val}); end
  endtask

  task automatic test_comp_line;
    int fc, nf, nr, nu, rc, nb; logic fcomp; logic [31:0] fa; logic [31:0] ra [4];
    run_line(32'h0000_1040, 1'b1, 0, 0, 0, 0, 1'b0, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (nr != 4) begin failures++; $display("FAIL comp_nreq got=%0d exp=4", nr); end
    checks++; if (ra[0] !== 32'h1040 || ra[1] !== 32'h1044 || ra[2] !== 32'h1048 || ra[3] !== 32'h104C) begin
      failures++; $display("FAIL comp_req_addrs got=%h %h %h %h exp=1040 1044 1048 104c", ra[0], ra[1], ra[2], ra[3]);
    end
    checks++; if (fc != 9 || fcomp !== 1'b1 || nf != 1 || nb != 0) begin failures++; $display("FAIL comp_fill got cyc=%0d comp=%b n=%0d both=%0d exp cyc=9 comp=1 n=1 both=0", fc, fcomp, nf, nb); end
    checks++; if (fa !== 32'h1040) begin failures++; $display("FAIL comp_fill_addr got=%h exp=1040", fa); end
    checks++; if (rc != 10) begin failures++; $display("FAIL comp_next_ready got=%0d exp=10", rc); end
    checks++; if (comp_fill_data !== exp_comp(32'h1040)) begin failures++; $display("FAIL comp_data got=%h exp=%h", comp_fill_data, exp_comp(32'h1040)); end
    checks++; if (raw_fill_data !== 128'hEFB3104C_EFB71048_EFBB1044_EFBF1040) begin failures++; $display("FAIL comp_raw_slots got=%h", raw_fill_data); end
    checks++; if (stat_comp_lines !== 3'd1 || stat_raw_lines !== 3'd0) begin failures++; $display("FAIL comp_stats comp=%0d raw=%0d exp 1/0", stat_comp_lines, stat_raw_lines); end
  endtask

  task automatic test_raw_fallback;
    int fc, nf, nr, nu, rc, nb; logic fcomp; logic [31:0] fa; logic [31:0] ra [4];
    run_line(32'h0000_1040, 1'b1, 0, 0, 0, 0, 1'b1, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (fc != 9 || fcomp !== 1'b0 || nf != 1 || nb != 0) begin failures++; $display("FAIL raw_fill got cyc=%0d comp=%b n=%0d both=%0d exp cyc=9 comp=0 n=1 both=0", fc, fcomp, nf, nb); end
    checks++; if (raw_fill_data !== 128'hEFB3104C_EFB71048_EFBB1044_EFBF1040) begin failures++; $display("FAIL raw_data got=%h", raw_fill_data); end
    checks++; if (stat_comp_lines !== 3'd1 || stat_raw_lines !== 3'd1) begin failures++; $display("FAIL raw_stats comp=%0d raw=%0d exp 1/1", stat_comp_lines, stat_raw_lines); end
  endtask

  task automatic test_latched_mode;
    int fc, nf, nr, nu, rc, nb; logic fcomp; logic [31:0] fa; logic [31:0] ra [4];
    run_line(32'h0000_1040, 1'b1, 0, 3, 0, 0, 1'b0, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (fc != 9 || fcomp !== 1'b1) begin failures++; $display("FAIL latched_fill got cyc=%0d comp=%b exp cyc=9 comp=1", fc, fcomp); end
    checks++; if (stat_comp_lines !== 3'd2 || stat_raw_lines !== 3'd1) begin failures++; $display("FAIL latched_stats comp=%0d raw=%0d exp 2/1", stat_comp_lines, stat_raw_lines); end
  endtask

  task automatic test_flush;
    int fc, nf, nr, nu, rc, nb; logic fcomp; logic [31:0] fa; logic [31:0] ra [4];
    run_line(32'h0000_1040, 1'b1, 0, 0, 6, 0, 1'b0, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (nf != 0) begin failures++; $display("FAIL flush_no_fill got=%0d exp=0", nf); end
    checks++; if (rc != 7) begin failures++; $display("FAIL flush_ready got=%0d exp=7", rc); end
    checks++; if (nr != 3) begin failures++; $display("FAIL flush_nreq got=%0d exp=3", nr); end
    checks++; if (stat_comp_lines !== 3'd2 || stat_raw_lines !== 3'd1) begin failures++; $display("FAIL flush_stats comp=%0d raw=%0d exp 2/1", stat_comp_lines, stat_raw_lines); end
  endtask

  task automatic test_stall;
    int fc, nf, nr, nu, rc, nb; logic fcomp; logic [31:0] fa; logic [31:0] ra [4];
    run_line(32'h0000_1040, 1'b1, 5, 0, 0, 0, 1'b0, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (fc != 14 || fcomp !== 1'b1) begin failures++; $display("FAIL stall_fill got cyc=%0d comp=%b exp cyc=14 comp=1", fc, fcomp); end
    checks++; if (nu != 0 || ra[0] !== 32'h1040) begin failures++; $display("FAIL stall_addr unstable=%0d first=%h exp 0/1040", nu, ra[0]); end
    checks++; if (nr != 4) begin failures++; $display("FAIL stall_nreq got=%0d exp=4", nr); end
    checks++; if (stat_comp_lines !== 3'd3) begin failures++; $display("FAIL stall_stats comp=%0d exp=3", stat_comp_lines); end
  endtask

  task automatic test_reset_mid;
    int fc, nf, nr, nu, rc, nb; logic fcomp; logic [31:0] fa; logic [31:0] ra [4];
    run_line(32'h0000_1040, 1'b1, 0, 0, 0, 4, 1'b0, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (nf != 0) begin failures++; $display("FAIL rstmid_no_fill got=%0d exp=0", nf); end
    checks++; if (stat_comp_lines !== '0 || stat_raw_lines !== '0 || raw_fill_data !== 128'h0) begin
      failures++; $display("FAIL rstmid_cleared comp=%0d raw=%0d data=%h exp 0", stat_comp_lines, stat_raw_lines, raw_fill_data);
    end
    run_line(32'h0000_2087, 1'b0, 0, 0, 0, 0, 1'b0, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (ra[0] !== 32'h2080) begin failures++; $display("FAIL rstmid_new_base got=%h exp=2080", ra[0]); end
    checks++; if (fc != 9 || fcomp !== 1'b0 || nf != 1 || fa !== 32'h2080) begin
      failures++; $display("FAIL rstmid_fill cyc=%0d comp=%b n=%0d addr=%h exp 9/0/1/2080", fc, fcomp, nf, fa);
    end
    checks++; if (raw_fill_data !== 128'hDF73208C_DF772088_DF7B2084_DF7F2080) begin failures++; $display("FAIL rstmid_raw_data got=%h", raw_fill_data); end
    checks++; if (stat_comp_lines !== 3'd0 || stat_raw_lines !== 3'd1) begin failures++; $display("FAIL rstmid_stats comp=%0d raw=%0d exp 0/1", stat_comp_lines, stat_raw_lines); end
  endtask

  task automatic test_saturation;
    int fc, nf, nr, nu, rc, nb; logic fcomp; logic [31:0] fa; logic [31:0] ra [4];
    for (int n = 0; n < 7; n++)
      run_line(32'h0000_3000, 1'b1, 0, 0, 0, 0, 1'b0, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (stat_comp_lines !== 3'd7) begin failures++; $display("FAIL sat_reach got=%0d exp=7", stat_comp_lines); end
    run_line(32'h0000_3000, 1'b1, 0, 0, 0, 0, 1'b0, fc, nf, fcomp, fa, ra, nr, nu, rc, nb);
    checks++; if (stat_comp_lines !== 3'd7 || fcomp !== 1'b1 || nf != 1) begin
      failures++; $display("FAIL sat_hold got=%0d comp=%b n=%0d exp 7/1/1", stat_comp_lines, fcomp, nf);
    end
    checks++; if (stat_raw_lines !== 3'd1) begin failures++; $display("FAIL sat_raw_untouched got=%0d exp=1", stat_raw_lines); end
  endtask

  initial begin
    test_reset();
    test_comp_line();
    test_raw_fallback();
    test_latched_mode();
    test_flush();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
